// File: rtl/ucode_pkg.sv
// Shared constants for the microcode decode sequencer: default widths and phase encoding.
package ucode_pkg;

   localparam int DEF_OP_W   = 4;
   localparam int DEF_FLAG_W = 2;
   localparam int DEF_CW_W   = 13;
   localparam int DEF_DEPTH  = 16;

   typedef enum logic {
      PHASE_FETCH = 1'b0,
      PHASE_EXEC  = 1'b1
   } phase_e;

   // Lookup key is {opcode, flags, phase}.
   function automatic int key_width(input int op_w, input int flag_w);
      return op_w + flag_w + 1;
   endfunction

endpackage

// File: rtl/ucode_match_table.sv
// Combinational ternary match of a key against DEPTH entries; lowest matching index wins.
module ucode_match_table #(
   parameter int K     = 7,
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic [K-1:0]     key,
   input  logic [K-1:0]     ent_key  [DEPTH],
   input  logic [K-1:0]     ent_care [DEPTH],
   input  logic [DEPTH-1:0] ent_valid,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   logic [DEPTH-1:0] match;

   // A cleared care bit removes that key bit from the comparison.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = ent_valid[i] && (((key ^ ent_key[i]) & ent_care[i]) == '0);
      end
   end

   // Scanning from the top down lets the lowest matching index overwrite the result last.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ucode_decode_seq.sv
// Two-phase microcode decoder: a writable ternary pattern table maps {instr, flags, phase} to a control word.
// Optional registered miss flag output cw_miss is enabled by defining UCODE_MISS_FLAG_EN.
module ucode_decode_seq
   import ucode_pkg::*;
#(
   parameter int              OP_W       = DEF_OP_W,
   parameter int              FLAG_W     = DEF_FLAG_W,
   parameter int              CW_W       = DEF_CW_W,
   parameter int              DEPTH      = DEF_DEPTH,
   parameter logic [CW_W-1:0] DEFAULT_CW = '0,
   localparam int             K          = OP_W + FLAG_W + 1,
   localparam int             IDX_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [OP_W-1:0]   instr,
   input  logic [FLAG_W-1:0] flags,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [K-1:0]      wr_key,
   input  logic [K-1:0]      wr_care,
   input  logic [CW_W-1:0]   wr_cw,
`ifdef UCODE_MISS_FLAG_EN
   output logic              cw_miss,
`endif
   output logic [CW_W-1:0]   cw,
   output logic              cw_valid,
   output logic              phase
);

   // en is a single-cycle advance strobe with no back-pressure: each cycle it is high
   // the lookup registers into cw and the phase toggles; cw_valid marks that cycle's result.

   phase_e            state_q;
   phase_e            state_d;

   logic [K-1:0]      key_mem  [DEPTH];
   logic [K-1:0]      care_mem [DEPTH];
   logic [CW_W-1:0]   cw_mem   [DEPTH];
   logic [DEPTH-1:0]  valid_q;

   logic [K-1:0]      lookup_key;
   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [CW_W-1:0]   lookup_cw;
   logic              miss_q;

   // Phase FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PHASE_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Phase FSM: next state
   always_comb begin
      state_d = state_q;
      if (en) begin
         state_d = (state_q == PHASE_FETCH) ? PHASE_EXEC : PHASE_FETCH;
      end
   end

   // Phase FSM: outputs
   always_comb begin
      phase = (state_q == PHASE_EXEC);
   end

   assign lookup_key = {instr, flags, phase};

   ucode_match_table #(
      .K     (K),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_match (
      .key       (lookup_key),
      .ent_key   (key_mem),
      .ent_care  (care_mem),
      .ent_valid (valid_q),
      .hit       (hit),
      .idx       (hit_idx)
   );

   assign lookup_cw = hit ? cw_mem[hit_idx] : DEFAULT_CW;

   // Entry payloads are not reset; only the valid bits gate their use.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         key_mem[wr_idx]  <= wr_key;
         care_mem[wr_idx] <= wr_care;
         cw_mem[wr_idx]   <= wr_cw;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // The lookup above sees pre-write table contents, so a same-cycle write lands one lookup later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cw       <= '0;
         cw_valid <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         cw_valid <= en;
         if (en) begin
            cw     <= lookup_cw;
            miss_q <= !hit;
         end
      end
   end

`ifdef UCODE_MISS_FLAG_EN
   assign cw_miss = miss_q;
`else
   logic unused_miss;
   assign unused_miss = miss_q;
`endif

endmodule

// File: tb/tb_ucode_decode_seq.sv
// Directed self-checking bench for ucode_decode_seq with hand-computed expected values.
module tb_ucode_decode_seq;

   localparam logic [12:0] DEF_CW = 13'h1555;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  instr;
   logic [1:0]  flags;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [6:0]  wr_key;
   logic [6:0]  wr_care;
   logic [12:0] wr_cw;
   logic [12:0] cw;
   logic        cw_valid;
   logic        phase;
`ifdef UCODE_MISS_FLAG_EN
   logic        cw_miss;
`endif

   int assert_cnt = 0;
   int fail_cnt   = 0;

   ucode_decode_seq #(
      .DEFAULT_CW (DEF_CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .instr    (instr),
      .flags    (flags),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_key   (wr_key),
      .wr_care  (wr_care),
      .wr_cw    (wr_cw),
`ifdef UCODE_MISS_FLAG_EN
      .cw_miss  (cw_miss),
`endif
      .cw       (cw),
      .cw_valid (cw_valid),
      .phase    (phase)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [12:0] e_cw, input logic e_valid,
                            input logic e_phase);
      check_eq({tag, "_cw"}, 32'(cw), 32'(e_cw));
      check_eq({tag, "_valid"}, 32'(cw_valid), 32'(e_valid));
      check_eq({tag, "_phase"}, 32'(phase), 32'(e_phase));
   endtask

   task automatic check_miss(input string tag, input logic e_miss);
`ifdef UCODE_MISS_FLAG_EN
      check_eq({tag, "_miss"}, 32'(cw_miss), 32'(e_miss));
`else
      if (e_miss === 1'bx) $display("note: %s", tag);
`endif
   endtask

   // driver tasks
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic write_entry(input logic [3:0] idx, input logic [6:0] key, input logic [6:0] care,
                              input logic [12:0] wcw);
      wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_care = care; wr_cw = wcw;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic lookup(input logic [3:0] i, input logic [1:0] f);
      en = 1'b1; instr = i; flags = f;
      tick();
      en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; instr = '0; flags = '0;
      wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_care = '0; wr_cw = '0;
      do_reset();
      check_out("reset", 13'h0000, 1'b0, 1'b0);
      check_miss("reset", 1'b0);

      // empty table lookup returns the default word
      lookup(4'd3, 2'b01);
      check_out("empty", DEF_CW, 1'b1, 1'b1);
      check_miss("empty", 1'b1);

      // entry 0 matches only fetch phase; phase now 1
      write_entry(4'd0, 7'b0000000, 7'b0000001, 13'h1001);
      check_out("idle_after_wr", DEF_CW, 1'b0, 1'b1);
      lookup(4'd5, 2'b10);
      check_out("e0_exec", DEF_CW, 1'b1, 1'b0);
      lookup(4'd9, 2'b11);
      check_out("e0_fetch", 13'h1001, 1'b1, 1'b1);
      check_miss("e0_fetch", 1'b0);

      // priority between overlapping entries and a catch-all in the top slot
      do_reset();
      check_out("reset2", 13'h0000, 1'b0, 1'b0);
      write_entry(4'd2, 7'b1000111, 7'b1111111, 13'h0A5A);
      write_entry(4'd5, 7'b1000001, 7'b1111001, 13'h0111);
      lookup(4'd0, 2'b00);
      check_out("miss_fetch", DEF_CW, 1'b1, 1'b1);
      lookup(4'd8, 2'b11);
      check_out("prio_e2", 13'h0A5A, 1'b1, 1'b0);
      lookup(4'd0, 2'b00);
      check_out("miss_fetch2", DEF_CW, 1'b1, 1'b1);
      lookup(4'd8, 2'b01);
      check_out("wild_e5", 13'h0111, 1'b1, 1'b0);
      write_entry(4'd15, 7'b0101010, 7'b0000000, 13'h1234);
      lookup(4'd0, 2'b00);
      check_out("catchall_e15", 13'h1234, 1'b1, 1'b1);
      lookup(4'd8, 2'b11);
      check_out("prio_over_e15", 13'h0A5A, 1'b1, 1'b0);

      // write and lookup in the same cycle
      do_reset();
      write_entry(4'd3, 7'b0011100, 7'b1111111, 13'h0001);
      wr_en = 1'b1; wr_idx = 4'd3; wr_key = 7'b0011100; wr_care = 7'b1111111; wr_cw = 13'h0002;
      lookup(4'd3, 2'b10);
      wr_en = 1'b0;
      check_out("wr_same_cycle", 13'h0001, 1'b1, 1'b1);
      lookup(4'd3, 2'b10);
      check_out("wr_exec_miss", DEF_CW, 1'b1, 1'b0);
      lookup(4'd3, 2'b10);
      check_out("wr_visible", 13'h0002, 1'b1, 1'b1);

      // en pattern 1,0,0,1 with the entry rewritten while idle
      do_reset();
      write_entry(4'd0, 7'b0000000, 7'b0000000, 13'h1ABC);
      check_out("seq_p0", 13'h0000, 1'b0, 1'b0);
      lookup(4'd1, 2'b00);
      check_out("seq_en1", 13'h1ABC, 1'b1, 1'b1);
      write_entry(4'd0, 7'b0000000, 7'b0000000, 13'h0BBB);
      check_out("seq_en0a", 13'h1ABC, 1'b0, 1'b1);
      tick();
      check_out("seq_en0b", 13'h1ABC, 1'b0, 1'b1);
      lookup(4'd1, 2'b00);
      check_out("seq_en1b", 13'h0BBB, 1'b1, 1'b0);

      // reset mid-sequence beats en and wr_en
      lookup(4'd2, 2'b01);
      check_out("pre_rst", 13'h0BBB, 1'b1, 1'b1);
      rst_n = 1'b0; en = 1'b1;
      wr_en = 1'b1; wr_idx = 4'd0; wr_key = '0; wr_care = '0; wr_cw = 13'h1FFF;
      tick();
      rst_n = 1'b1; en = 1'b0; wr_en = 1'b0;
      check_out("mid_rst", 13'h0000, 1'b0, 1'b0);
      check_miss("mid_rst", 1'b0);
      lookup(4'd2, 2'b01);
      check_out("post_rst", DEF_CW, 1'b1, 1'b1);
      check_miss("post_rst", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/ucode_decode_seq.md
UCODE_DECODE_SEQ -- requirements
Module: ucode_decode_seq

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have parameter FLAG_W, default 2, condition-flag width.
REQ-003 SHALL have parameter CW_W, default 13, control-word width.
REQ-004 SHALL have parameter DEPTH, default 16, number of pattern-table entries (power of two, 2..64).
REQ-005 SHALL have parameter DEFAULT_CW, default all-zeros, control word driven on table miss.
REQ-006 SHALL have one clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 en  input  1  advance: perform one lookup and toggle phase this cycle.
REQ-010 instr  input  OP_W  opcode under decode.
REQ-011 flags  input  FLAG_W  condition flags (e.g. carry, zero).
REQ-012 wr_en  input  1  table write strobe.
REQ-013 wr_idx  input  log2(DEPTH)  entry written.
REQ-014 wr_key  input  K=OP_W+FLAG_W+1  match value {opcode, flags, phase}.
REQ-015 wr_care  input  K  care mask; 0 bit = don't-care.
REQ-016 wr_cw  input  CW_W  control word stored with entry.
REQ-017 cw  output  CW_W  registered control word.
REQ-018 cw_valid  output  1  cw updated by the lookup of the previous cycle.
REQ-019 phase  output  1  current phase, 0=fetch, 1=execute.

Function
REQ-020 Lookup key SHALL be {instr, flags, phase}, phase in bit 0.
REQ-021 Entry i SHALL match when valid_i and ((key ^ key_i) & care_i)==0.
REQ-022 Lowest-index matching entry SHALL win; no match SHALL yield DEFAULT_CW.
REQ-023 When en=1, cw SHALL load the lookup result at that edge; latency one cycle; cw_valid=1 the following cycle.
REQ-024 When en=0, cw SHALL hold, cw_valid SHALL be 0, phase SHALL hold.
REQ-025 When en=1, phase SHALL toggle at the same edge the lookup registers (lookup uses pre-toggle phase).
REQ-026 wr_en=1 SHALL write key, care, cw and set valid for wr_idx at the edge.
REQ-027 Simultaneous wr_en and en SHALL look up with pre-write contents; the write is visible from the next cycle.
REQ-028 Writing wr_care all-zeros SHALL make the entry match every key.

Reset
REQ-029 rst_n=0 at an edge SHALL clear all entry valid bits, cw to 0, cw_valid to 0, phase to 0.
REQ-030 Reset SHALL take priority over en and wr_en in the same cycle; reset mid-sequence SHALL restart at fetch with an empty table.
REQ-031 Stored key/care/cw contents need not be reset.

Configuration
REQ-032 With UCODE_MISS_FLAG_EN defined, SHALL add output cw_miss (1 bit), registered alongside cw, 1 when the lookup hit no entry, reset 0, held when en=0.
REQ-033 Without UCODE_MISS_FLAG_EN, cw_miss SHALL not exist and behaviour is otherwise identical.

Structure
REQ-034 Package ucode_pkg SHALL hold PHASE_FETCH/PHASE_EXEC constants and the default widths OP_W, FLAG_W, CW_W, DEPTH.
REQ-035 Priority match/encode SHALL be a sub-module ucode_match_table (combinational match of key against DEPTH entries, returning hit and winning index).

Verification
REQ-036 Reset, then en=1 with empty table -> cw=DEFAULT_CW next cycle, cw_valid=1, phase toggles 0->1.
REQ-037 Entry 0 key=7'b0000000 care=7'b0000001 cw=13'h1001; en=1 at phase 0, any instr/flags -> cw=13'h1001; at phase 1 -> DEFAULT_CW.
REQ-038 Entry 2 care all-ones key {4'b1000,2'b11,1'b1} cw=13'h0A5A, entry 5 key {4'b1000,2'bxx,1} care 7'b1111001 cw=13'h0111; instr=8 flags=11 phase 1 -> 13'h0A5A; flags=01 -> 13'h0111.
REQ-039 wr_en and en same cycle rewriting the matching entry's cw 13'h0001->13'h0002 -> cw=13'h0001, next lookup with same key -> 13'h0002.
REQ-040 en toggled 1,0,0,1 -> cw holds and cw_valid=0 during en=0 cycles; phase sequence 0,1,1,1,0.
REQ-041 rst_n=0 mid-sequence with en=1 -> cw=0, cw_valid=0, phase=0, subsequent lookup returns DEFAULT_CW (and cw_miss=1 when UCODE_MISS_FLAG_EN defined).
